preload_sequencer: RTL
======================

# preload_sequencer

Front-end controller that sits directly upstream of the pre-load unit. It accepts independent valid/ready streams of 8-bit weights and 7-bit activations and writes each full SIZE×SIZE tile into the pre-load unit's weight and activation memories. It then sequences the pre-load unit's control levels (`load_mem_done`, `PreLoad_CWeight`, `Cal`) through weight processing, compensation-weight preload and calculation, and signals completion.

## Interface
- `SIZE`, 8, systolic array dimension
- `MEM_SIZE`, SIZE*SIZE, entries per tile
- `ADDR_WIDTH`, $clog2(MEM_SIZE), memory address width
- `PROCESS_CYCLES`, MEM_SIZE+SIZE, cycles spent in PROCESS (WPU reduction/compensation extraction)
- `CWEIGHT_CYCLES`, 3*SIZE, cycles `PreLoad_CWeight` is held high
- `CAL_CYCLES`, 3*SIZE, cycles `Cal` is held high
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous, active-low
- `start` in 1: begin one tile; sampled only in IDLE
- `abort` in 1: synchronous return to IDLE from any state
- `w_valid` in 1 / `w_data` in 8 / `w_ready` out 1: weight stream
- `a_valid` in 1 / `a_data` in 7 / `a_ready` out 1: activation stream
- `Weight` out 8 / `Weight_Mem_Address_in` out ADDR_WIDTH: registered weight write data/address
- `Activation` out 7 / `Activation_Mem_Address_in` out ADDR_WIDTH: registered activation write data/address
- `load_mem_done` out 1 / `PreLoad_CWeight` out 1 / `Cal` out 1: pre-load unit controls
- `busy` out 1: state != IDLE
- `done` out 1: one-cycle pulse at end of tile
- `err` out 1: sticky protocol error (see Configuration)

## Operation
- States: IDLE → LOAD → FLUSH → PROCESS → PRELOAD → CAL → DONE → IDLE.
- IDLE: all control outputs 0. `start`=1 → LOAD.
- LOAD: `w_ready` = (w_cnt < MEM_SIZE); `a_ready` = (a_cnt < MEM_SIZE). Counters are ADDR_WIDTH+1 bits. On a weight handshake, `Weight`<=`w_data`, `Weight_Mem_Address_in`<=w_cnt[ADDR_WIDTH-1:0], w_cnt++. Activations are handled identically on their own channel. Streams are fully independent and may complete in either order. When both counts equal MEM_SIZE, → FLUSH.
- Data/address outputs hold their last value outside handshakes. Because the memories rewrite identical data, holding is harmless.
- FLUSH: one cycle, `load_mem_done`=0, so the final registered write lands. → PROCESS.
- PROCESS: `load_mem_done`=1 for PROCESS_CYCLES cycles. → PRELOAD.
- PRELOAD: `load_mem_done`=1, `PreLoad_CWeight`=1 for CWEIGHT_CYCLES. → CAL.
- CAL: `load_mem_done`=1, `PreLoad_CWeight`=0, `Cal`=1 for CAL_CYCLES. → DONE.
- DONE: `done`=1 and `load_mem_done`=1 for one cycle. → IDLE. Counters clear.
- Phase counter is shared and reloads on every state entry. Width is $clog2(max(PROCESS_CYCLES,CWEIGHT_CYCLES,CAL_CYCLES)+1).
- `abort`=1 in any state → IDLE next cycle. Counters clear, controls drop, no `done`. `abort` has priority over `start` and over handshakes in the same cycle (no transfer occurs).
- `start` while busy is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, `err` 0.
- `start` at cycle 0 → `busy`=1 and ready high at cycle 1.
- Handshake at cycle t → `Weight`/address valid at t+1.
- Last handshake of the later stream at t → FLUSH at t+1, `load_mem_done` rises at t+2.
- `PreLoad_CWeight` rises at t+2+PROCESS_CYCLES; `Cal` rises CWEIGHT_CYCLES later.
- `done` pulses at t+2+PROCESS_CYCLES+CWEIGHT_CYCLES+CAL_CYCLES. IDLE is reached the next cycle, so `start` can be accepted then.
- With continuous streams, LOAD lasts exactly MEM_SIZE cycles. Ready drops in the cycle after a stream's count reaches MEM_SIZE (no over-acceptance).

## Configuration
- `PRELOAD_SEQ_ERR_EN` defined:
  - `err` is set when `w_valid` or `a_valid` is high while the corresponding ready is low outside LOAD, or when `start` arrives while busy.
  - `err` is sticky and clears only on reset or on an accepted `start` in IDLE.
- Not defined: `err` is tied to 0 and no detection logic is present.

## Test plan
- SIZE=8, both streams continuous from cycle 1 → 64 writes, addresses 0..63 in order, `load_mem_done` rises at cycle 66, `done` pulses at cycle 66+72+24+24=186.
- Weights finish, then activations arrive with 1-in-3 `a_valid` → `w_ready` drops after 64 weights, FLUSH occurs only after activation 63, final `Activation_Mem_Address_in`=63 is held through FLUSH.
- `abort` in PRELOAD at its 5th cycle → next cycle all controls 0, `busy`=0, no `done`; a following `start` reloads from address 0.
- `abort` and a handshake in the same LOAD cycle → no address increment, returns to IDLE.
- With `PRELOAD_SEQ_ERR_EN`, `w_valid`=1 during CAL → `err`=1 and stays set until the next `start`. Without the macro, `err`=0 throughout.
- `rst` low mid-PROCESS → all outputs 0 immediately (asynchronous), state IDLE.

Source files
------------

// File: rtl/preload_sequencer.sv
// preload_sequencer
// Front-end controller for the pre-load unit. It takes two independent
// valid/ready streams (8-bit weights, 7-bit activations), writes one full
// SIZE x SIZE tile into the weight and activation memories, and then steps
// the pre-load unit's control levels through the weight-processing,
// compensation-weight preload and calculation phases before pulsing done.
//
// Optional build macro: PRELOAD_SEQ_ERR_EN. When it is defined, a sticky
// protocol-error flag is produced. When it is not defined, err is tied low.
//
// Ports
//   clk                        rising-edge clock
//   rst                        asynchronous active-low reset
//   start                      begin one tile (sampled in IDLE only)
//   abort                      synchronous return to IDLE from any state
//   w_valid/w_data/w_ready     weight stream
//   a_valid/a_data/a_ready     activation stream
//   Weight/Weight_Mem_Address_in          registered weight write port
//   Activation/Activation_Mem_Address_in  registered activation write port
//   load_mem_done/PreLoad_CWeight/Cal     pre-load unit control levels
//   busy                       high whenever the sequencer is not idle
//   done                       one-cycle pulse at the end of a tile
//   err                        sticky protocol error
module preload_sequencer #(
    parameter int unsigned SIZE           = 8,
    parameter int unsigned MEM_SIZE       = SIZE * SIZE,
    parameter int unsigned ADDR_WIDTH     = $clog2(MEM_SIZE),
    parameter int unsigned PROCESS_CYCLES = MEM_SIZE + SIZE,
    parameter int unsigned CWEIGHT_CYCLES = 3 * SIZE,
    parameter int unsigned CAL_CYCLES     = 3 * SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  w_valid,
    input  logic [7:0]            w_data,
    output logic                  w_ready,
    input  logic                  a_valid,
    input  logic [6:0]            a_data,
    output logic                  a_ready,
    output logic [7:0]            Weight,
    output logic [ADDR_WIDTH-1:0] Weight_Mem_Address_in,
    output logic [6:0]            Activation,
    output logic [ADDR_WIDTH-1:0] Activation_Mem_Address_in,
    output logic                  load_mem_done,
    output logic                  PreLoad_CWeight,
    output logic                  Cal,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned CNT_W   = ADDR_WIDTH + 1;
    localparam int unsigned MAX_PC  = (PROCESS_CYCLES > CWEIGHT_CYCLES) ? PROCESS_CYCLES : CWEIGHT_CYCLES;
    localparam int unsigned MAX_ALL = (MAX_PC > CAL_CYCLES) ? MAX_PC : CAL_CYCLES;
    localparam int unsigned PH_W    = $clog2(MAX_ALL + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_FLUSH   = 3'd2;
    localparam logic [2:0] S_PROCESS = 3'd3;
    localparam logic [2:0] S_PRELOAD = 3'd4;
    localparam logic [2:0] S_CAL     = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]            state, state_next;
    logic [PH_W-1:0]       phase, phase_next;
    logic [CNT_W-1:0]      w_cnt, w_cnt_next;
    logic [CNT_W-1:0]      a_cnt, a_cnt_next;
    logic                  w_fire, a_fire;

    logic                  w_ready_next, a_ready_next;
    logic [7:0]            weight_next;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic [6:0]            act_next;
    logic [ADDR_WIDTH-1:0] a_addr_next;
    logic                  load_mem_done_next, cweight_next, cal_next;
    logic                  busy_next, done_next;

    // State, counters and every output are registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                     <= S_IDLE;
            phase                     <= '0;
            w_cnt                     <= '0;
            a_cnt                     <= '0;
            w_ready                   <= 1'b0;
            a_ready                   <= 1'b0;
            Weight                    <= '0;
            Weight_Mem_Address_in     <= '0;
            Activation                <= '0;
            Activation_Mem_Address_in <= '0;
            load_mem_done             <= 1'b0;
            PreLoad_CWeight           <= 1'b0;
            Cal                       <= 1'b0;
            busy                      <= 1'b0;
            done                      <= 1'b0;
        end else begin
            state                     <= state_next;
            phase                     <= phase_next;
            w_cnt                     <= w_cnt_next;
            a_cnt                     <= a_cnt_next;
            w_ready                   <= w_ready_next;
            a_ready                   <= a_ready_next;
            Weight                    <= weight_next;
            Weight_Mem_Address_in     <= w_addr_next;
            Activation                <= act_next;
            Activation_Mem_Address_in <= a_addr_next;
            load_mem_done             <= load_mem_done_next;
            PreLoad_CWeight           <= cweight_next;
            Cal                       <= cal_next;
            busy                      <= busy_next;
            done                      <= done_next;
        end
    end

    // Next-state, counter and output decode. Outputs are derived from the
    // next state so that they line up with the state register.
    always_comb begin
        state_next  = state;
        phase_next  = phase;
        w_cnt_next  = w_cnt;
        a_cnt_next  = a_cnt;
        w_fire      = 1'b0;
        a_fire      = 1'b0;
        weight_next = Weight;
        w_addr_next = Weight_Mem_Address_in;
        act_next    = Activation;
        a_addr_next = Activation_Mem_Address_in;

        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_next = S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Ready registers already encode count < MEM_SIZE.
                    w_fire = w_valid & w_ready;
                    a_fire = a_valid & a_ready;
                    if (w_fire) begin
                        weight_next = w_data;
                        w_addr_next = w_cnt[ADDR_WIDTH-1:0];
                        w_cnt_next  = w_cnt + CNT_W'(1);
                    end
                    if (a_fire) begin
                        act_next    = a_data;
                        a_addr_next = a_cnt[ADDR_WIDTH-1:0];
                        a_cnt_next  = a_cnt + CNT_W'(1);
                    end
                    // Leave as soon as the last write of the later stream is taken.
                    if ((w_cnt_next == CNT_W'(MEM_SIZE)) && (a_cnt_next == CNT_W'(MEM_SIZE))) begin
                        state_next = S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    state_next = S_PROCESS;
                    phase_next = PH_W'(PROCESS_CYCLES - 1);
                end
                S_PROCESS: begin
                    if (phase == '0) begin
                        state_next = S_PRELOAD;
                        phase_next = PH_W'(CWEIGHT_CYCLES - 1);
                    end else begin
                        phase_next = phase - PH_W'(1);
                    end
                end
                S_PRELOAD: begin
                    if (phase == '0) begin
                        state_next = S_CAL;
                        phase_next = PH_W'(CAL_CYCLES - 1);
                    end else begin
                        phase_next = phase - PH_W'(1);
                    end
                end
                S_CAL: begin
                    if (phase == '0) begin
                        state_next = S_DONE;
                        phase_next = '0;
                    end else begin
                        phase_next = phase - PH_W'(1);
                    end
                end
                S_DONE: begin
                    state_next = S_IDLE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end

        // Returning to IDLE (normal end or abort) clears all counters.
        if (state_next == S_IDLE) begin
            w_cnt_next = '0;
            a_cnt_next = '0;
            phase_next = '0;
        end

        busy_next          = (state_next != S_IDLE);
        w_ready_next       = (state_next == S_LOAD) && (w_cnt_next < CNT_W'(MEM_SIZE));
        a_ready_next       = (state_next == S_LOAD) && (a_cnt_next < CNT_W'(MEM_SIZE));
        load_mem_done_next = (state_next == S_PROCESS) || (state_next == S_PRELOAD) ||
                             (state_next == S_CAL)     || (state_next == S_DONE);
        cweight_next       = (state_next == S_PRELOAD);
        cal_next           = (state_next == S_CAL);
        done_next          = (state_next == S_DONE);
    end

`ifdef PRELOAD_SEQ_ERR_EN
    logic start_accept;
    logic proto_viol;

    assign start_accept = (state == S_IDLE) && start && !abort;
    // Data offered while the sequencer cannot take it, or a start while busy.
    assign proto_viol   = ((state != S_LOAD) && ((w_valid && !w_ready) || (a_valid && !a_ready))) ||
                          (start && (state != S_IDLE));

    // Sticky error; an accepted start opens a fresh tile with a clean flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (start_accept) begin
            err <= 1'b0;
        end else if (proto_viol) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
